line_buffer_reader: RTL
=======================

Name: line_buffer_reader

Overview:
- Producer end of the row-window interface consumed by the parallel next-state engine. Streams a stored Game-of-Life generation out of BRAM one row at a time.
- For each target row r it presents a three-row window (rows r-1, r, r+1) with zero rows past the top and bottom edges. It also supplies the row index and the qualifiers calc_flg/valid_set.
- Sits between the current-generation BRAM read port and the next-state engine. The engine writes results into a separate next-generation buffer; ping-pong swapping is outside this block.

Parameters:
- row_length, 1280, cells per row (width of BRAM data and row outputs)
- num_rows, 720, rows per generation; must be >= 2
- addr_width, 10, width of BRAM row address and calc_row_in; 2^addr_width >= num_rows

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- start  input  1  one-cycle request to stream one full generation; ignored unless idle
- bram_rd_en  output  1  BRAM read enable
- bram_rd_addr  output  addr_width  BRAM row address to read
- bram_rd_data  input  row_length  BRAM read data, valid exactly 1 cycle after bram_rd_en
- top_row  output  row_length  row r-1, or all zeros when r=0
- middle_row  output  row_length  row r
- bottom_row  output  row_length  row r+1, or all zeros when r=num_rows-1
- calc_row_in  output  addr_width  target row index r
- calc_flg  output  1  high for the whole streaming pass
- valid_set  output  1  one-cycle pulse: the window for row r is valid
- busy  output  1  high in every state except IDLE
- done  output  1  one-cycle pulse after the last row's hold cycle

Behaviour:
- All outputs are registered. On reset every output is 0, all row registers are 0, and the FSM goes to IDLE.
- Reset is asynchronous and may occur mid-pass: the pass is abandoned with no partial done pulse, and the block then waits for a new start.
- FSM states: IDLE -> PRIME0 -> PRIME1 -> PRIME2 -> {PRESENT <-> HOLD} -> DONE -> IDLE.
- IDLE: when start=1 at a clock edge, go to PRIME0.
- PRIME0: bram_rd_en=1, addr=0, calc_flg=1.
- PRIME1: bram_rd_en=1, addr=1. At exit: middle_row<=bram_rd_data (row 0), top_row<=0.
- PRIME2: bram_rd_en=0. At exit: bottom_row<=bram_rd_data (row 1), calc_row_in<=0.
- PRESENT (row r): valid_set=1.
  - If r+2<num_rows: bram_rd_en=1, addr=r+2.
  - Otherwise bram_rd_en=0.
- HOLD (row r): valid_set=0; the window and calc_row_in stay unchanged. This covers the consumer's registered write cycle, in which its combinational result must still reflect row r.
  - At exit, if r<num_rows-1: top<=middle, middle<=bottom, bottom<=(r+2<num_rows ? bram_rd_data : 0), calc_row_in<=r+1, then go to PRESENT.
  - At exit, if r=num_rows-1: go to DONE.
- DONE: calc_flg=0, done=1 for one cycle, then IDLE.
- Timing: the cycle after start is sampled is cycle 1 (PRIME0). valid_set for row r is high in cycle 4+2r. done is high in cycle 2*num_rows+4.
- valid_set and calc_flg are never both low while a window is being presented. calc_flg stays high from PRIME0 through the last HOLD.
- Edge rows: top_row is exactly zero for r=0. bottom_row is exactly zero for r=num_rows-1. No BRAM read is ever issued with an address >= num_rows.
- start asserted while busy has no effect; the pass continues unchanged.
- The window registers hold their last values in IDLE; consumers qualify with valid_set.

Test Plan:
- row_length=8, num_rows=4; BRAM rows 0x81,0x42,0x24,0x18; start pulse -> cycle 4: valid_set=1, top=0x00, mid=0x81, bot=0x42, calc_row_in=0; cycle 10: top=0x24, mid=0x18, bot=0x00, calc_row_in=3; done high in cycle 12 only.
- Same setup, monitor the read port -> addresses exactly 0,1,2,3 (cycles 1,2,4,6), each once; no read issued at or after cycle 8; valid_set pulses exactly 4 times; window stable across each PRESENT/HOLD pair.
- num_rows=2, rows 0xFF,0x0F -> row 0 window {0x00,0xFF,0x0F}, row 1 window {0xFF,0x0F,0x00}; done in cycle 8.
- start re-pulsed in cycles 3 and 7 during a pass -> no change to sequence or timing; exactly one done pulse.
- rst asserted asynchronously in cycle 6, released in cycle 8 -> all outputs 0 immediately, no done; a new start yields a correct full pass from row 0.
- Two back-to-back passes (start again the cycle after done) -> the second pass is identical to the first, with valid_set for row 0 in cycle 4 relative to its start.

Source files
------------

// File: rtl/line_buffer_reader.sv
// rtl/line_buffer_reader.sv - streams a stored generation out of BRAM as three-row windows
//
// Purpose:
//   Reads one Game-of-Life generation from the current-generation BRAM, one row per
//   two cycles. For each target row r it presents rows r-1, r and r+1, using zero rows
//   beyond the top and bottom edges. The window is valid for one cycle (o_valid_set)
//   and then held for one more cycle while the consumer registers its result.
//
// Ports:
//   i_clk            system clock, rising edge
//   i_rst            asynchronous active-high reset
//   i_start          one-cycle request to stream a generation (ignored unless idle)
//   o_bram_rd_en     BRAM read enable
//   o_bram_rd_addr   BRAM row address
//   i_bram_rd_data   BRAM read data, valid one cycle after o_bram_rd_en
//   o_top_row        row r-1, or zero when r = 0
//   o_middle_row     row r
//   o_bottom_row     row r+1, or zero when r = num_rows-1
//   o_calc_row_in    target row index r
//   o_calc_flg       high for the whole streaming pass
//   o_valid_set      one-cycle pulse marking a valid window
//   o_busy           high whenever the FSM is not idle
//   o_done           one-cycle pulse after the last row's hold cycle

module line_buffer_reader #(
    parameter int row_length = 1280,
    parameter int num_rows   = 720,
    parameter int addr_width = 10
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_start,
    output logic                  o_bram_rd_en,
    output logic [addr_width-1:0] o_bram_rd_addr,
    input  logic [row_length-1:0] i_bram_rd_data,
    output logic [row_length-1:0] o_top_row,
    output logic [row_length-1:0] o_middle_row,
    output logic [row_length-1:0] o_bottom_row,
    output logic [addr_width-1:0] o_calc_row_in,
    output logic                  o_calc_flg,
    output logic                  o_valid_set,
    output logic                  o_busy,
    output logic                  o_done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRIME0,
        S_PRIME1,
        S_PRIME2,
        S_PRESENT,
        S_HOLD,
        S_DONE
    } state_t;

    // Two extra bits so that r+2 / r+3 never wrap before comparing against num_rows.
    localparam logic [addr_width+1:0] NUM_W    = (addr_width+2)'(num_rows);
    localparam logic [addr_width-1:0] LAST_ROW = addr_width'(num_rows - 1);

    state_t                  r_state;
    logic                    r_rd_en;
    logic [addr_width-1:0]   r_rd_addr;
    logic [row_length-1:0]   r_top;
    logic [row_length-1:0]   r_middle;
    logic [row_length-1:0]   r_bottom;
    logic [addr_width-1:0]   r_row;
    logic                    r_calc_flg;
    logic                    r_valid_set;
    logic                    r_busy;
    logic                    r_done;

    logic [addr_width+1:0]   w_row_p2;
    logic [addr_width+1:0]   w_row_p3;

    // w_row_p2: row fetched during the current PRESENT (r+2).
    // w_row_p3: row to fetch in the next PRESENT, i.e. (r+1)+2.
    assign w_row_p2 = {2'b00, r_row} + (addr_width+2)'(2);
    assign w_row_p3 = {2'b00, r_row} + (addr_width+2)'(3);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= S_IDLE;
            r_rd_en     <= 1'b0;
            r_rd_addr   <= '0;
            r_top       <= '0;
            r_middle    <= '0;
            r_bottom    <= '0;
            r_row       <= '0;
            r_calc_flg  <= 1'b0;
            r_valid_set <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_state    <= S_PRIME0;
                        r_rd_en    <= 1'b1;
                        r_rd_addr  <= '0;
                        r_calc_flg <= 1'b1;
                        r_busy     <= 1'b1;
                    end
                end
                S_PRIME0: begin
                    r_state   <= S_PRIME1;
                    r_rd_en   <= 1'b1;
                    r_rd_addr <= addr_width'(1);
                end
                S_PRIME1: begin
                    // Row 0 read data arrives now.
                    r_state  <= S_PRIME2;
                    r_rd_en  <= 1'b0;
                    r_middle <= i_bram_rd_data;
                    r_top    <= '0;
                end
                S_PRIME2: begin
                    // Row 1 read data arrives now; first PRESENT prefetches row 2.
                    r_state     <= S_PRESENT;
                    r_bottom    <= i_bram_rd_data;
                    r_row       <= '0;
                    r_valid_set <= 1'b1;
                    if (NUM_W > (addr_width+2)'(2)) begin
                        r_rd_en   <= 1'b1;
                        r_rd_addr <= addr_width'(2);
                    end else begin
                        r_rd_en   <= 1'b0;
                    end
                end
                S_PRESENT: begin
                    r_state     <= S_HOLD;
                    r_valid_set <= 1'b0;
                    r_rd_en     <= 1'b0;
                end
                S_HOLD: begin
                    if (r_row == LAST_ROW) begin
                        r_state    <= S_DONE;
                        r_calc_flg <= 1'b0;
                        r_done     <= 1'b1;
                    end else begin
                        r_state     <= S_PRESENT;
                        r_top       <= r_middle;
                        r_middle    <= r_bottom;
                        // Data returned here is row r+2, read during the PRESENT cycle.
                        r_bottom    <= (w_row_p2 < NUM_W) ? i_bram_rd_data : '0;
                        r_row       <= r_row + addr_width'(1);
                        r_valid_set <= 1'b1;
                        if (w_row_p3 < NUM_W) begin
                            r_rd_en   <= 1'b1;
                            r_rd_addr <= w_row_p3[addr_width-1:0];
                        end else begin
                            r_rd_en   <= 1'b0;
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_bram_rd_en   = r_rd_en;
    assign o_bram_rd_addr = r_rd_addr;
    assign o_top_row      = r_top;
    assign o_middle_row   = r_middle;
    assign o_bottom_row   = r_bottom;
    assign o_calc_row_in  = r_row;
    assign o_calc_flg     = r_calc_flg;
    assign o_valid_set    = r_valid_set;
    assign o_busy         = r_busy;
    assign o_done         = r_done;

endmodule
